// File: rtl/stmt_stream_arbiter.sv
// Round-robin arbiter that lends one declaration checker to N_REQ byte sources, one statement per grant.
// Optional stall abort is enabled by defining STMT_ARB_TIMEOUT_EN.
module stmt_stream_arbiter #(
   parameter int N_REQ   = 2,
   parameter int MAX_LEN = 255,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     src_valid,
   input  logic [8*N_REQ-1:0]   src_data,
   output logic [N_REQ-1:0]     src_ready,
   output logic [7:0]           chk_in,
   output logic                 chk_en,
   output logic                 chk_reset,
   input  logic                 chk_out,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 res_valid,
   output logic [1:0]           res_id,
   output logic                 res_ok,
   output logic                 res_err,
   output logic [7:0]           res_len
);

   localparam logic [7:0] SEMI      = 8'h3B;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   if (N_REQ < 2 || N_REQ > 4 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_param_check
      $error("stmt_stream_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, CLR, STREAM, SAMPLE, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [1:0]        owner, last_grant, win;
   logic              found;
   logic [N_REQ-1:0]  win_hot, own_hot;
   logic              own_valid;
   logic [7:0]        own_byte;
   logic [7:0]        len;
   logic              accept, drain_done, stall_hit;

   // Search order starts just after the previous winner.
   always_comb begin
      found = 1'b0;
      win   = last_grant;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && src_valid[i] && ((32'(last_grant) + k) % N_REQ) == i) begin
               found = 1'b1;
               win   = 2'(i);
            end
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         win_hot[i] = (win == 2'(i));
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_byte  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         own_hot[i] = (owner == 2'(i));
         if (owner == 2'(i)) begin
            own_valid = src_valid[i];
            own_byte  = src_data[8*i +: 8];
         end
      end
   end

`ifdef STMT_ARB_TIMEOUT_EN
   localparam int unsigned SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall;

   always_ff @(posedge clk) begin
      if (reset || state == CLR || accept) stall <= '0;
      else if (state == STREAM)            stall <= stall + SW'(1);
   end

   assign stall_hit = (state == STREAM) && (stall == SW'(TIMEOUT - 1));
`else
   assign stall_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      src_ready  = '0;
      chk_en     = 1'b0;
      chk_in     = '0;
      accept     = 1'b0;
      drain_done = 1'b0;
      busy       = (state != IDLE);
      chk_reset  = reset | (state == CLR);
      case (state)
         IDLE:   if (found) state_nxt = CLR;
         CLR:    state_nxt = STREAM;
         STREAM: begin
            src_ready = own_hot;
            if (own_valid) begin
               chk_en = 1'b1;
               chk_in = own_byte;
               accept = 1'b1;
               if (own_byte == SEMI)                 state_nxt = SAMPLE;
               else if (len + 8'd1 == MAX_LEN_B)     state_nxt = DRAIN;
            end else if (stall_hit) begin
               state_nxt = IDLE;
            end
         end
         SAMPLE: state_nxt = IDLE;
         DRAIN: begin
            src_ready = own_hot;
            if (own_valid && own_byte == SEMI) begin
               drain_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant      <= '0;
         owner      <= '0;
         last_grant <= 2'(N_REQ - 1);
         len        <= '0;
         res_valid  <= 1'b0;
         res_id     <= '0;
         res_ok     <= 1'b0;
         res_err    <= 1'b0;
         res_len    <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: if (found) begin
               grant      <= win_hot;
               owner      <= win;
               last_grant <= win;
            end
            CLR: len <= '0;
            STREAM: begin
               if (accept) len <= len + 8'd1;
               if (!own_valid && stall_hit) begin
                  res_valid <= 1'b1;
                  res_ok    <= 1'b0;
                  res_err   <= 1'b1;
                  res_id    <= owner;
                  res_len   <= len;
                  grant     <= '0;
               end
            end
            SAMPLE: begin
               res_valid <= 1'b1;
               res_ok    <= chk_out;
               res_err   <= 1'b0;
               res_id    <= owner;
               res_len   <= len;
               grant     <= '0;
            end
            DRAIN: if (drain_done) begin
               res_valid <= 1'b1;
               res_ok    <= 1'b0;
               res_err   <= 1'b1;
               res_id    <= owner;
               res_len   <= MAX_LEN_B;
               grant     <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
